// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  // Round-robin search after reset starts at requester 0.
  localparam logic [ID_W-1:0] LAST_ID_RST = 2'b11;

endpackage : arb_pkg

// File: rtl/priority_pick4.sv
// Combinational winner selection over a masked request vector.
// Fixed mode picks the highest set index; round-robin mode scans upward
// from start_i with wrap and takes the first set bit.
module priority_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             rr_mode_i,
  input  logic [ID_W-1:0]  start_i,
  output logic [ID_W-1:0]  id_o,
  output logic             found_o
);

  logic [ID_W-1:0] idx;

  // Select the winning index according to the active mode.
  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    idx     = '0;
    if (rr_mode_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = start_i + ID_W'(i);
        if (!found_o && req_i[idx]) begin
          id_o    = idx;
          found_o = 1'b1;
        end
      end
    end else begin
      // Ascending scan, so the last hit (highest index) wins.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_i[i]) begin
          id_o    = ID_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule : priority_pick4

// File: rtl/req_arbiter4.sv
// Registered 4-requester arbiter with hold limit, fixed/round-robin pick
// and global enable. gnt_id is the downstream mux select.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no grant outstanding
//   GRANT | gnt_id_q owns the resource, hold_q cycles so far
module req_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rr_mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  arb_state_e       state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
  logic             valid_q,   valid_d;
  logic [CNT_W-1:0] hold_q,    hold_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;

  logic [N_REQ-1:0] pick_mask;
  logic [ID_W-1:0]  pick_start;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;
  logic             holder_req;

  // While granted, the holder is masked out: it either released or timed out.
  assign pick_mask  = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign pick_start = last_id_q + ID_W'(1);
  assign holder_req = req[gnt_id_q];

  priority_pick4 u_pick (
    .req_i     (pick_mask),
    .rr_mode_i (rr_mode),
    .start_i   (pick_start),
    .id_o      (pick_id),
    .found_o   (pick_found)
  );

  // Next-state and next-output decision.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    last_id_d = last_id_q;

    if (!enable) begin
      state_d  = IDLE;
      gnt_d    = '0;
      gnt_id_d = '0;
      valid_d  = 1'b0;
      hold_d   = '0;
    end else if (state_q == GRANT && holder_req && hold_q < HOLD_MAX) begin
      hold_d = hold_q + HOLD_ONE;
    end else if (pick_found) begin
      state_d   = GRANT;
      gnt_d     = N_REQ'(1) << pick_id;
      gnt_id_d  = pick_id;
      valid_d   = 1'b1;
      hold_d    = HOLD_ONE;
      last_id_d = pick_id;
    end else if (state_q == GRANT && holder_req) begin
      // Timed out with nobody waiting: regrant the holder.
      hold_d = HOLD_ONE;
    end else begin
      state_d  = IDLE;
      gnt_d    = '0;
      gnt_id_d = '0;
      valid_d  = 1'b0;
      hold_d   = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      last_id_q <= LAST_ID_RST;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      last_id_q <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;

endmodule : req_arbiter4
